// File: rtl/mem_seq_pkg.sv
// Shared types for the memory request sequencer: FSM states and the queued request record.
// Address/data widths are fixed here because the request struct is built from them.
package mem_seq_pkg;
  localparam int AW = 5;
  localparam int DW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_req_t;
endpackage

// File: rtl/mem_seq_fifo.sv
// Synchronous request FIFO; head entry is visible on dout whenever not empty.
module mem_seq_fifo
  import mem_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  mem_req_t                 din,
  output mem_req_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  mem_req_t      store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr];

  // Pointers are exactly PW bits, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_req_sequencer.sv
// Buffers read/write requests and issues them one at a time as single-cycle mem strobes,
// returning read data on a valid/ready response port after a fixed read latency.
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy,
  output seq_state_t    dbg_state
);
  // Handshakes: a transfer happens on a posedge where valid && ready; valid holds its payload
  // until accepted, and ready never depends combinationally on valid.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  seq_state_t           state;
  logic [CW-1:0]        lat_cnt;
  mem_req_t             head;
  mem_req_t             req_in;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 push;
  logic                 pop;

  assign req_ready = !fifo_full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign req_in    = '{write: req_write, addr: req_addr, data: req_wdata};
  assign busy      = (fifo_count != '0) || (state != IDLE);
  assign dbg_state = state;

  mem_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (req_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The popped command is held directly in the mem-side output registers, so address and
  // write data keep their last value after the strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mem_write   <= head.write;
            mem_read    <= !head.write;
            mem_addr    <= head.addr;
            mem_data_in <= head.data;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if (mem_write) begin
            state <= IDLE;
          end else begin
            lat_cnt <= CW'(RD_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            rsp_rdata <= mem_data_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_sequencer.sv
// Randomized bench for mem_req_sequencer with a transaction-level reference model and a mem model.
module tb_mem_req_sequencer;
  import mem_seq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int RD_LAT = 1;
  localparam int NA     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          busy;
  seq_state_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_req_sequencer #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mem model: data valid exactly RD_LAT cycles after the read strobe cycle, junk otherwise
  logic [DW-1:0]     mem_arr [NA];
  logic [RD_LAT-1:0] rd_v;
  logic [DW-1:0]     rd_d [RD_LAT];
  logic [DW-1:0]     junk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v <= '0;
      for (int i = 0; i < NA; i++) mem_arr[i] <= '0;
    end else begin
      if (mem_write) mem_arr[mem_addr] <= mem_data_in;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
      rd_v[0] <= mem_read;
      rd_d[0] <= mem_arr[mem_addr];
      junk    <= DW'($urandom);
    end
  end
  assign mem_data_out = rd_v[RD_LAT-1] ? rd_d[RD_LAT-1] : junk;

  // response-ready driver
  logic rsp_rand = 1'b0;
  logic rsp_hold = 1'b1;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_hold;
    end
  end

  // scoreboard: requests in acceptance order; read results from a shadow memory kept in that order
  logic [DW-1:0]    shadow [NA];
  logic [AW+DW:0]   exp_issue_q[$];
  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    rsp_log[$];
  logic [AW+DW:0]   e;
  int outstanding = 0, strobe_cnt = 0, last_wr_cyc = -1, last_rd_cyc = -1, rsp_rise_cyc = -1;
  logic prev_strobe = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_issue_q.delete();
        exp_q.delete();
        for (int i = 0; i < NA; i++) shadow[i] = '0;
        outstanding = 0;
        prev_strobe = 1'b0;
        prev_valid  = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          exp_issue_q.push_back({req_write, req_addr, req_wdata});
          if (req_write) shadow[req_addr] = req_wdata;
          else exp_q.push_back(shadow[req_addr]);
        end
        if (mem_read || mem_write) begin
          check("strobe_excl", 32'(mem_read & mem_write), 0);
          check("strobe_width", 32'(prev_strobe), 0);
          check("issue_stall", outstanding, 0);
          if (exp_issue_q.size() == 0) check("unexp_strobe", 1, 0);
          else begin
            e = exp_issue_q.pop_front();
            check("strobe_kind", 32'(mem_write), 32'(e[AW+DW]));
            check("mem_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
            if (mem_write) check("mem_wdata", 32'(mem_data_in), 32'(e[DW-1:0]));
          end
          strobe_cnt++;
          if (mem_write) last_wr_cyc = cyc;
          else begin
            last_rd_cyc = cyc;
            outstanding++;
          end
        end
        prev_strobe = mem_read || mem_write;
        if (prev_valid && !prev_ready) begin
          check("rsp_hold_valid", 32'(rsp_valid), 1);
          check("rsp_hold_data", 32'(rsp_rdata), 32'(prev_data));
        end
        if (rsp_valid && !prev_valid) begin
          rsp_rise_cyc = cyc;
          check("rsp_expected", outstanding, 1);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) check("unexp_rsp", 1, 0);
          else check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
          rsp_log.push_back(rsp_rdata);
          outstanding--;
        end
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;
        prev_data  = rsp_rdata;
      end
    end
  end

  // driver tasks (called just after a posedge; return just after the accepting posedge)
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n0, c0, s0, t;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    wait_cyc(3);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_strobes", 32'({mem_read, mem_write}), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    #2 rst = 1'b0;
    wait_cyc(1);
    check("post_rst_ready", 32'(req_ready), 1);

    // write then read same address, with latency checks; response held off for 10 cycles
    n0 = cyc;
    send(1'b1, 5'h03, 8'hA5);
    wait_cyc(3);
    check("wr_latency", last_wr_cyc, n0 + 2);
    rsp_hold = 1'b0;
    n0 = cyc;
    send(1'b0, 5'h03, 8'h00);
    wait_cyc(6);
    check("rd_latency", last_rd_cyc, n0 + 2);
    check("rsp_latency", rsp_rise_cyc, n0 + 3 + RD_LAT);
    send(1'b1, 5'h07, 8'h5A);
    s0 = strobe_cnt;
    wait_cyc(10);
    check("stall_no_strobe", strobe_cnt, s0);
    check("stall_rsp_valid", 32'(rsp_valid), 1);
    check("stall_rsp_data", 32'(rsp_rdata), 32'h A5);
    check("stall_busy", 32'(busy), 1);
    rsp_hold = 1'b1;
    wait_cyc(8);
    check("wr_after_rsp", strobe_cnt, s0 + 1);
    check("rsp_a5", 32'(rsp_log[rsp_log.size()-1]), 32'h A5);

    // fill FIFO while FSM is parked in RESP
    rsp_hold = 1'b0;
    send(1'b0, 5'h07, 8'h00);
    wait_cyc(5);
    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) send(1'b1, AW'(8 + i), DW'(8'h30 + i));
    check("b2b_accept", cyc - c0, DEPTH);
    wait_cyc(2);
    check("full_ready", 32'(req_ready), 0);
    check("full_busy", 32'(busy), 1);
    rsp_hold = 1'b1;
    c0 = cyc;
    send(1'b1, 5'h0C, 8'h3C);
    check("fifth_after_pop", 32'(cyc - c0 > 1), 1);
    wait_cyc(20);
    check("fill_drained", exp_issue_q.size() + exp_q.size(), 0);

    // interleaved ordering
    rsp_log.delete();
    send(1'b1, 5'h01, 8'h11);
    send(1'b0, 5'h01, 8'h00);
    send(1'b1, 5'h01, 8'h22);
    send(1'b0, 5'h01, 8'h00);
    wait_cyc(20);
    check("ilv_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      check("ilv_first", 32'(rsp_log[0]), 32'h11);
      check("ilv_second", 32'(rsp_log[1]), 32'h22);
    end

    // fill/drain 3x across all addresses, then random traffic with random rsp_ready
    rsp_rand = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < NA; a++)
        send(1'($urandom_range(0, 1)), AW'(a), DW'($urandom));
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, NA - 1)), DW'($urandom));
      wait_cyc($urandom_range(0, 3));
    end
    rsp_rand = 1'b0;
    rsp_hold = 1'b1;
    t = 0;
    while ((busy || rsp_valid) && t < 400) begin
      wait_cyc(1);
      t++;
    end
    check("drain_busy", 32'(busy), 0);
    check("drain_queues", exp_issue_q.size() + exp_q.size(), 0);

    // reset while a read is waiting for data
    send(1'b0, 5'h05, 8'h00);
    wait_cyc(2);
    check("in_wait", 32'(dbg_state), 32'(WAIT));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_strobes", 32'({mem_read, mem_write}), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_wdata", 32'(mem_data_in), 0);
    check("mid_rst_rsp", 32'({rsp_valid, rsp_rdata}), 0);
    check("mid_rst_ready_busy", 32'({req_ready, busy}), 0);
    wait_cyc(2);
    #2 rst = 1'b0;
    wait_cyc(3);
    check("after_rst_ready", 32'(req_ready), 1);
    check("after_rst_busy", 32'(busy), 0);
    check("after_rst_rsp", 32'(rsp_valid), 0);
    rsp_log.delete();
    send(1'b1, 5'h09, 8'hC3);
    send(1'b0, 5'h09, 8'h00);
    wait_cyc(12);
    check("after_rst_rd_cnt", rsp_log.size(), 1);
    if (rsp_log.size() == 1) check("after_rst_rd", 32'(rsp_log[0]), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
